// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between operand fetch, the ALU pipe and writeback.
// Latency: none, wires only.
// Backpressure: valid/ready on both the operand side and the result side.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             zero;
    logic             carry;
    logic             overflow;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, opcode, A, B, out_ready,
        input  in_ready, out_valid, Sum, zero, carry, overflow
    );

    // The ALU pipe itself.
    modport slave (
        input  in_valid, opcode, A, B, out_ready,
        output in_ready, out_valid, Sum, zero, carry, overflow
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: ADD/XOR/NOR/OR/AND/SL/SR/constant with zero/carry/overflow flags.
// Latency: 2 clk edges from input accept to out_valid; one result per cycle when unstalled.
// Backpressure: a stalled output holds its result; S1 fills, then in_ready drops combinationally.
module alu_pipe #(
    parameter int WIDTH       = 32,
    parameter int SHAMT_W     = $clog2(WIDTH),
    parameter int DEFAULT_VAL = 69
) (
    input  logic    clk,
    input  logic    rst_n,
    alu_pipe_if.slave io
);
    localparam logic [WIDTH-1:0] DEF_RESULT = WIDTH'(DEFAULT_VAL);

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_entry_t;

    s1_entry_t        s1_q;
    logic             s1_valid;
    logic             s2_advance;
    logic             s1_advance;

    logic [WIDTH:0]   add_full;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0] result;
    logic             res_carry;
    logic             res_overflow;

    // An empty or draining stage can take new content this edge.
    assign s2_advance  = !io.out_valid || io.out_ready;
    assign s1_advance  = !s1_valid || s2_advance;
    assign io.in_ready = s1_advance;

    assign add_full = {1'b0, s1_q.a} + {1'b0, s1_q.b};
    assign shamt    = s1_q.b[SHAMT_W-1:0];

    // Result mux and ADD flags computed from the S1 registers.
    always_comb begin
        result       = '0;
        res_carry    = 1'b0;
        res_overflow = 1'b0;
        case (s1_q.op)
            3'b000: begin
                result       = add_full[WIDTH-1:0];
                res_carry    = add_full[WIDTH];
                res_overflow = (s1_q.a[WIDTH-1] == s1_q.b[WIDTH-1]) &&
                               (add_full[WIDTH-1] != s1_q.a[WIDTH-1]);
            end
            3'b001:  result = s1_q.a ^ s1_q.b;
            3'b010:  result = ~(s1_q.a | s1_q.b);
            3'b011:  result = s1_q.a | s1_q.b;
            3'b100:  result = s1_q.a & s1_q.b;
            3'b101:  result = s1_q.a << shamt;
            3'b110:  result = s1_q.a >> shamt;
            default: result = DEF_RESULT;
        endcase
    end

    // Stage 1: capture operands on accept; a bubble enters when nothing is offered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_advance) begin
            s1_valid <= io.in_valid;
            if (io.in_valid) begin
                s1_q.op <= io.opcode;
                s1_q.a  <= io.A;
                s1_q.b  <= io.B;
            end
        end
    end

    // Stage 2: register result and flags; everything holds while the output is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io.out_valid <= 1'b0;
            io.Sum       <= '0;
            io.zero      <= 1'b0;
            io.carry     <= 1'b0;
            io.overflow  <= 1'b0;
        end else if (s2_advance) begin
            io.out_valid <= s1_valid;
            if (s1_valid) begin
                io.Sum      <= result;
                io.zero     <= (result == '0);
                io.carry    <= res_carry;
                io.overflow <= res_overflow;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: reset, every opcode, ADD flags, backpressure stream,
// shift-amount masking and mid-stream reset, all against hand-computed values.
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    alu_pipe_if #(.WIDTH(32)) bus ();

    alu_pipe #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = v;
        bus.opcode   = op;
        bus.A        = a;
        bus.B        = b;
    endtask

    logic [31:0] op_exp [8];

    initial begin
        int          next_i;
        int          got_idx;
        logic        acc;
        logic        stalled;
        logic [31:0] held;

        op_exp[0] = 32'hF0F0_0013; op_exp[1] = 32'hF0F0_000B;
        op_exp[2] = 32'h0F0F_FFF0; op_exp[3] = 32'hF0F0_000F;
        op_exp[4] = 32'h0000_0004; op_exp[5] = 32'h0F00_00F0;
        op_exp[6] = 32'h0F0F_0000; op_exp[7] = 32'h0000_0045;

        // Reset held 3 cycles with a valid input offered.
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b000, 32'd5, 32'd7);
        repeat (3) step();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_sum", bus.Sum, 32'h0);
        check("rst_flags", {bus.zero, bus.carry, bus.overflow}, 3'b000);
        rst_n = 1'b1;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        step();
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_no_output", bus.out_valid, 1'b0);

        // Every opcode with the same operand pair.
        for (int op = 0; op < 8; op++) begin
            drive(1'b1, 3'(op), 32'hF0F0_000F, 32'h0000_0004);
            step();
            drive(1'b0, 3'b000, 32'd0, 32'd0);
            check($sformatf("op%0d_lat1_valid", op), bus.out_valid, 1'b0);
            step();
            check($sformatf("op%0d_valid", op), bus.out_valid, 1'b1);
            check($sformatf("op%0d_sum", op), bus.Sum, op_exp[op]);
            if (op != 0)
                check($sformatf("op%0d_carry_ovf", op), {bus.carry, bus.overflow}, 2'b00);
        end
        step();
        check("idle_valid_clears", bus.out_valid, 1'b0);

        // ADD flags: signed overflow, then unsigned wrap to zero.
        drive(1'b1, 3'b000, 32'h7FFF_FFFF, 32'h1);
        step();
        drive(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h1);
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        check("ovf_sum", bus.Sum, 32'h8000_0000);
        check("ovf_flags_zco", {bus.zero, bus.carry, bus.overflow}, 3'b001);
        step();
        check("wrap_sum", bus.Sum, 32'h0);
        check("wrap_flags_zco", {bus.zero, bus.carry, bus.overflow}, 3'b110);
        step();

        // Backpressure: 8 back-to-back ADDs, output stalled in cycles 3-7.
        next_i  = 0;
        got_idx = 0;
        stalled = 1'b0;
        held    = '0;
        for (int c = 0; c < 40 && got_idx < 8; c++) begin
            bus.out_ready = !(c >= 3 && c <= 7);
            if (next_i < 8) drive(1'b1, 3'b000, 32'(next_i), 32'd100);
            else            drive(1'b0, 3'b000, 32'd0, 32'd0);
            #1;
            if (stalled) begin
                check($sformatf("bp_hold_valid_c%0d", c), bus.out_valid, 1'b1);
                check($sformatf("bp_hold_sum_c%0d", c), bus.Sum, held);
            end
            if (c >= 3 && c <= 7)
                check($sformatf("bp_in_ready_c%0d", c), bus.in_ready, 1'b0);
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("bp_out%0d", got_idx), bus.Sum, 32'(100 + got_idx));
                got_idx++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.Sum;
            step();
            if (acc) next_i++;
        end
        check("bp_all_received", got_idx, 8);
        bus.out_ready = 1'b1;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        step();
        check("bp_no_extra", bus.out_valid, 1'b0);

        // Shift amount uses only the low bits of B.
        drive(1'b1, 3'b101, 32'h1, 32'h0000_0021);
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        step();
        check("shamt_mask", bus.Sum, 32'h2);
        step();

        // Reset with two entries in flight behind a stalled output.
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'h0AAA, 32'h1);
        step();
        drive(1'b1, 3'b000, 32'h0BBB, 32'h1);
        step();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        check("mid_full_in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", bus.out_valid, 1'b0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("mid_rst_flushed%0d", k), bus.out_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
